// File: rtl/reorder_buffer.sv
// In-order retirement buffer: a circular queue of in-flight instructions that
// retires one ready entry per cycle and flushes everything when a branch turns out mispredicted.
module reorder_buffer #(
    parameter int unsigned ROB_INDEX_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic [31:0]              issue_pc,
    input  logic                     issue_pred_taken,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_value,
    output logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    output logic                     full,
    input  logic                     wb_valid,
    input  logic [ROB_INDEX_BIT-1:0] wb_rob_id,
    input  logic [31:0]              wb_value,
    input  logic                     wb_taken,
    input  logic [31:0]              wb_target,
    input  logic [ROB_INDEX_BIT-1:0] qry_id1,
    input  logic [ROB_INDEX_BIT-1:0] qry_id2,
    output logic                     qry_ready1,
    output logic                     qry_ready2,
    output logic [31:0]              qry_value1,
    output logic [31:0]              qry_value2,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_value,
    output logic [ROB_INDEX_BIT-1:0] commit_rob_id,
    output logic                     store_commit,
    output logic [ROB_INDEX_BIT-1:0] store_rob_id,
    output logic                     clear,
    output logic [31:0]              clear_pc
);
    localparam int unsigned DEPTH = 1 << ROB_INDEX_BIT;
    localparam int unsigned CW    = ROB_INDEX_BIT + 1;

    localparam logic [1:0] TYPE_REG = 2'd0;
    localparam logic [1:0] TYPE_BR  = 2'd1;
    localparam logic [1:0] TYPE_ST  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t                   entries [DEPTH];
    logic [DEPTH-1:0]         valid;
    logic [DEPTH-1:0]         ready;
    logic [ROB_INDEX_BIT-1:0] head;
    logic [ROB_INDEX_BIT-1:0] tail;
    logic [CW-1:0]            count;

    entry_t head_entry;
    logic   commit_fire;
    logic   mispredict;
    logic   issue_fire;
    logic   wb_fire;
    logic   bypass1;
    logic   bypass2;

    assign full         = (count == CW'(DEPTH));
    assign issue_rob_id = tail;

    // Retire/flush decisions use only state sampled before this edge.
    always_comb begin
        head_entry  = entries[head];
        commit_fire = (count != '0) && ready[head] && !clear;
        mispredict  = commit_fire && (head_entry.kind == TYPE_BR) &&
                      (head_entry.taken != head_entry.pred_taken);
        issue_fire  = issue_valid && !full && !clear && !mispredict;
        wb_fire     = wb_valid && valid[wb_rob_id] && !clear && !mispredict;
    end

    // Operand lookup with same-cycle writeback forwarding.
    assign bypass1    = wb_valid && (wb_rob_id == qry_id1);
    assign bypass2    = wb_valid && (wb_rob_id == qry_id2);
    assign qry_ready1 = ready[qry_id1] || bypass1;
    assign qry_ready2 = ready[qry_id2] || bypass2;
    assign qry_value1 = bypass1 ? wb_value : entries[qry_id1].value;
    assign qry_value2 = bypass2 ? wb_value : entries[qry_id2].value;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            valid         <= '0;
            ready         <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            store_commit  <= 1'b0;
            store_rob_id  <= '0;
            clear         <= 1'b0;
            clear_pc      <= '0;
        end else if (rdy_in) begin
            commit_rd    <= '0;
            store_commit <= 1'b0;
            clear        <= 1'b0;
            if (mispredict) begin
                // Branch retires (link write still happens), everything younger is discarded.
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                valid         <= '0;
                ready         <= '0;
                clear         <= 1'b1;
                clear_pc      <= head_entry.taken ? head_entry.target : head_entry.pc + 32'd4;
                commit_rd     <= head_entry.rd;
                commit_value  <= head_entry.value;
                commit_rob_id <= head;
            end else begin
                if (wb_fire) begin
                    ready[wb_rob_id]          <= 1'b1;
                    entries[wb_rob_id].value  <= wb_value;
                    entries[wb_rob_id].taken  <= wb_taken;
                    entries[wb_rob_id].target <= wb_target;
                end
                if (issue_fire) begin
                    entries[tail] <= '{kind: issue_type, rd: issue_rd, pc: issue_pc,
                                       pred_taken: issue_pred_taken, value: issue_value,
                                       taken: 1'b0, target: 32'd0};
                    valid[tail]   <= 1'b1;
                    ready[tail]   <= issue_ready;
                    tail          <= tail + ROB_INDEX_BIT'(1);
                end
                if (commit_fire) begin
                    valid[head] <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + ROB_INDEX_BIT'(1);
                    case (head_entry.kind)
                        TYPE_REG, TYPE_BR: begin
                            commit_rd     <= head_entry.rd;
                            commit_value  <= head_entry.value;
                            commit_rob_id <= head;
                        end
                        TYPE_ST: begin
                            store_commit <= 1'b1;
                            store_rob_id <= head;
                        end
                        default: ;
                    endcase
                end
                count <= count + CW'(issue_fire) - CW'(commit_fire);
            end
        end
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL use the following parameter and sizing: `ROB_INDEX_BIT (from const.v), default as defined there, index width; depth = 2^`ROB_INDEX_BIT entries.
REQ-002 The block SHALL provide port clk_in, input, 1, system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide port rst_in, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL provide port rdy_in, input, 1, low = pause; all registers hold.
REQ-005 The block SHALL provide port issue_valid, input, 1, issue request this cycle.
REQ-006 The block SHALL provide port issue_type, input, 2, entry type: 0=REG, 1=BR, 2=ST, 3=NOP.
REQ-007 The block SHALL provide port issue_rd, input, 5, destination register (REG only).
REQ-008 The block SHALL provide ports issue_pc (input, 32) and issue_pred_taken (input, 1): instruction PC and predicted direction.
REQ-009 The block SHALL provide ports issue_ready (input, 1) and issue_value (input, 32): result already known at issue.
REQ-010 The block SHALL provide port issue_rob_id, output, `ROB_INDEX_BIT, index the next issue will occupy (tail).
REQ-011 The block SHALL provide port full, output, 1, no free entry; upstream SHALL not issue.
REQ-012 The block SHALL provide ports wb_valid (input, 1), wb_rob_id (input, `ROB_INDEX_BIT) and wb_value (input, 32): execution writeback.
REQ-013 The block SHALL provide ports wb_taken (input, 1) and wb_target (input, 32): branch outcome (BR only).
REQ-014 The block SHALL provide query ports qry_id1/qry_id2 (input, `ROB_INDEX_BIT) with qry_ready1/qry_ready2 (output, 1) and qry_value1/qry_value2 (output, 32), combinational.
REQ-015 The block SHALL provide ports commit_rd (output, 5), commit_value (output, 32) and commit_rob_id (output, `ROB_INDEX_BIT): register-file write; commit_rd=0 means no write.
REQ-016 The block SHALL provide ports store_commit (output, 1) and store_rob_id (output, `ROB_INDEX_BIT): store may retire to memory.
REQ-017 The block SHALL provide ports clear (output, 1) and clear_pc (output, 32): mispredict flush and redirect PC.

Function
REQ-018 Storage SHALL be a circular buffer with head, tail and count registers; full = (count == depth); indices wrap modulo depth.
REQ-019 When issue_valid=1 and full=0, the block SHALL write the entry at tail (ready=issue_ready, value=issue_value) and increment tail, all in one edge; when full=1, issue SHALL be ignored.
REQ-020 When wb_valid=1, the block SHALL set entry wb_rob_id ready and store value, taken and target; writeback to an empty slot SHALL be ignored.
REQ-021 Commit SHALL occur when count>0, the head entry is ready and clear=0: at most one entry per cycle, head++.
REQ-022 Commit outputs SHALL be registered and valid for exactly the one cycle after the commit edge; at all other times commit_rd=0 and store_commit=0.
REQ-023 REG commit SHALL drive commit_rd=rd, commit_value=value, commit_rob_id=head index; rd=0 SHALL yield commit_rd=0.
REQ-024 ST commit SHALL pulse store_commit=1 with store_rob_id=head index; NOP commit SHALL produce no output pulse.
REQ-025 BR commit SHALL drive commit_rd=rd (link register, 0 if none); if taken != pred_taken, the block SHALL assert clear=1 next cycle with clear_pc = taken ? target : pc+4.
REQ-026 On a mispredict commit edge, head, tail and count SHALL reset to 0 and all valid bits SHALL clear; same-cycle issue and writeback SHALL be dropped.
REQ-027 While clear=1, issue_valid and wb_valid SHALL be ignored; clear SHALL deassert after one cycle.
REQ-028 Simultaneous issue and commit SHALL leave count unchanged; issue into a just-freed slot SHALL be permitted only in the following cycle (full is evaluated before commit).
REQ-029 Query: qry_readyN=1 if entry qry_idN is ready, or if wb_valid=1 and wb_rob_id=qry_idN (bypass, value=wb_value); otherwise qry_valueN is the stored value.
REQ-030 While rdy_in=0, the block SHALL change no state and hold all registered outputs.

Reset
REQ-031 Reset SHALL set head=tail=count=0, clear all valid/ready bits, and drive issue_rob_id=0, full=0, commit_rd=0, commit_value=0, commit_rob_id=0, store_commit=0, store_rob_id=0, clear=0, clear_pc=0.
REQ-032 Reset SHALL take priority over rdy_in and every other input, including mid-flush and mid-commit.

Verification
REQ-033 The bench SHALL cover: issue REG rd=5 issue_ready=0, wb id0 value 0x1234 -> next cycle commit_rd=5, commit_value=0x1234, commit_rob_id=0, for one cycle only.
REQ-034 The bench SHALL cover: issue depth entries with no writeback -> full=1, issue_rob_id wraps to 0; an extra issue is ignored; one commit -> full=0 the cycle after.
REQ-035 The bench SHALL cover: BR pc=0x100 pred_taken=0, wb taken=1 target=0x200 with two younger entries -> clear=1, clear_pc=0x200, count=0, younger entries never commit.
REQ-036 The bench SHALL cover: query id2 in the same cycle as wb id2 value 7 -> qry_ready=1, qry_value=7.
REQ-037 The bench SHALL cover: ST entry ready with rdy_in=0 for 3 cycles -> no commit; rdy_in=1 -> store_commit pulses once with the correct id.
REQ-038 The bench SHALL cover: rst_in during a nonempty buffer plus a pending mispredict -> all outputs 0 next cycle and no clear pulse.
